rs_alu_sched: RTL
=================

Name: rs_alu_sched

Overview:
8-entry ALU reservation station with wakeup and issue scheduling. It sits between the operand-fetch/dispatch stage and the single ALU. It buffers dispatched ops and snoops the CDB to capture missing operands. Each cycle it issues at most one fully-ready op to the ALU, picking the lowest ready slot index.

Parameters:
DEPTH, 8, number of entries (power of 2)
IDX_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
flush_i  in  1  mispredict flush; invalidates all entries
en_i  in  1  dispatch valid; writes one entry this cycle
A_i  in  32  operand A value (meaningful when A_rdy_i)
B_i  in  32  operand B value (meaningful when B_rdy_i)
A_rdy_i  in  1  operand A already available
B_rdy_i  in  1  operand B already available
A_id_i  in  5  ROB tag producing A when not ready
B_id_i  in  5  ROB tag producing B when not ready
Imm_i  in  32  immediate
OP_i  in  7  opcode
Funct7_i  in  7  funct7
Funct3_i  in  3  funct3
pc_i  in  32  instruction pc
ROB_id_i  in  5  destination ROB tag
cdb_en_i  in  1  CDB broadcast valid
cdb_rob_id_i  in  5  CDB producer tag
cdb_data_i  in  32  CDB result value
alu_rdy_i  in  1  ALU accepts an op this cycle
full_o  out  1  all DEPTH entries valid (combinational from state)
alu_en_o  out  1  registered issue valid, one cycle pulse per op
alu_A_o  out  32  issued operand A
alu_B_o  out  32  issued operand B
alu_Imm_o  out  32  issued immediate
alu_OP_o  out  7  issued opcode
alu_Funct7_o  out  7  issued funct7
alu_Funct3_o  out  3  issued funct3
alu_pc_o  out  32  issued pc
alu_ROB_id_o  out  5  issued ROB tag

Behaviour:
- Reset: all entry valid bits 0. All alu_* outputs 0, alu_en_o 0, full_o 0.
- Entry state: valid, A, B, A_rdy, B_rdy, A_id, B_id, Imm, OP, Funct7, Funct3, pc, ROB_id.
- Dispatch: when en_i=1 and flush_i=0, write the lowest-index free slot at the edge. en_i while full_o=1 is a dispatcher error; the RS ignores it and no entry changes.
- Wakeup: when cdb_en_i=1, every valid entry with A_rdy=0 and A_id==cdb_rob_id_i captures A=cdb_data_i and sets A_rdy=1. B behaves the same. Tags are compared only while the rdy bit is 0.
- Same-cycle dispatch and CDB: if the incoming A_rdy_i=0 and A_id_i matches the broadcast, the slot is written with A=cdb_data_i and A_rdy=1 (same for B). No op is lost.
- Issue select: ready = valid & A_rdy & B_rdy, evaluated on current registered state. Select the lowest-index ready slot.
- Issue: if a slot is selected, alu_rdy_i=1 and flush_i=0, then at the edge alu_* take the slot fields, alu_en_o=1, and the slot valid clears. Otherwise alu_en_o=0 and the other alu_* hold their value.
- Latency: dispatch at edge N with both operands ready gives earliest alu_en_o=1 after edge N+1. CDB wakeup at edge N gives earliest issue after edge N+1.
- A slot freed by issue at edge N is available to dispatch at edge N+1. full_o drops in the cycle after that issue edge.
- Flush: flush_i=1 clears all valid bits and forces alu_en_o=0 at the edge. Dispatch and issue in the same cycle are dropped. Flush has priority over everything except rst.
- rst asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
1. Dispatch ADD with A=5, B=7 both ready, ROB_id=3 -> alu_en_o=1 two edges later with alu_A_o=5, alu_B_o=7, alu_ROB_id_o=3; full_o stays 0.
2. Dispatch with A_rdy=0, A_id=9; 3 cycles later cdb_en_i=1, cdb_rob_id_i=9, cdb_data_i=0x1234 -> issue one cycle later with alu_A_o=0x1234; no issue before the broadcast.
3. Dispatch with A_id=4 in the same cycle that the CDB broadcasts tag 4, data 0xAA -> op issues with alu_A_o=0xAA and does not wait forever.
4. Fill 8 entries, all waiting on tag 2 -> full_o=1 and extra en_i ignored. Broadcast tag 2 -> slots issue in order 0..7 on consecutive cycles while alu_rdy_i=1; full_o=0 after the first issue.
5. Hold alu_rdy_i=0 with 2 ready entries -> alu_en_o stays 0 and entries are retained. Release -> slot 0 issues, then slot 1.
6. Flush_i with 5 valid entries and a ready op -> alu_en_o=0 next cycle, full_o=0, and no later issue. Async rst pulsed between edges -> outputs go to 0 immediately.

Source files
------------

// File: rtl/rs_alu_sched.sv
// ALU reservation station: buffers dispatched ops, captures missing operands from the CDB and
// issues the lowest-index ready op through a registered port (1 cycle); ops are held while alu_rdy_i is low.
module rs_alu_sched #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        en_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic        A_rdy_i,
    input  logic        B_rdy_i,
    input  logic [4:0]  A_id_i,
    input  logic [4:0]  B_id_i,
    input  logic [31:0] Imm_i,
    input  logic [6:0]  OP_i,
    input  logic [6:0]  Funct7_i,
    input  logic [2:0]  Funct3_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  ROB_id_i,
    input  logic        cdb_en_i,
    input  logic [4:0]  cdb_rob_id_i,
    input  logic [31:0] cdb_data_i,
    input  logic        alu_rdy_i,
    output logic        full_o,
    output logic        alu_en_o,
    output logic [31:0] alu_A_o,
    output logic [31:0] alu_B_o,
    output logic [31:0] alu_Imm_o,
    output logic [6:0]  alu_OP_o,
    output logic [6:0]  alu_Funct7_o,
    output logic [2:0]  alu_Funct3_o,
    output logic [31:0] alu_pc_o,
    output logic [4:0]  alu_ROB_id_o
);
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [4:0]  rob_id;
    } iss_t;

    typedef struct packed {
        logic        valid;
        logic        a_rdy;
        logic        b_rdy;
        logic [4:0]  a_id;
        logic [4:0]  b_id;
        iss_t        op;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             new_e;
    iss_t               iss_q, iss_d;
    logic               alu_en_q, alu_en_d;
    logic [DEPTH-1:0]   vld, rdy;
    logic               free_found, sel_found, do_disp, do_issue;
    logic [IDX_W-1:0]   free_idx, sel_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = ent_q[i].valid;
            rdy[i] = ent_q[i].valid & ent_q[i].a_rdy & ent_q[i].b_rdy;
        end
    end

    assign full_o = &vld;

    // Lowest-index priority encoders for the free slot and the issue candidate.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign do_disp  = en_i & ~flush_i & free_found;
    assign do_issue = sel_found & alu_rdy_i & ~flush_i;

    // Incoming op also snoops the current broadcast so a same-cycle wakeup is not missed.
    always_comb begin
        new_e           = '0;
        new_e.valid     = 1'b1;
        new_e.a_rdy     = A_rdy_i | (cdb_en_i & (A_id_i == cdb_rob_id_i));
        new_e.b_rdy     = B_rdy_i | (cdb_en_i & (B_id_i == cdb_rob_id_i));
        new_e.a_id      = A_id_i;
        new_e.b_id      = B_id_i;
        new_e.op.a      = A_rdy_i ? A_i : cdb_data_i;
        new_e.op.b      = B_rdy_i ? B_i : cdb_data_i;
        new_e.op.imm    = Imm_i;
        new_e.op.op     = OP_i;
        new_e.op.funct7 = Funct7_i;
        new_e.op.funct3 = Funct3_i;
        new_e.op.pc     = pc_i;
        new_e.op.rob_id = ROB_id_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (cdb_en_i && ent_q[i].valid && !ent_q[i].a_rdy && ent_q[i].a_id == cdb_rob_id_i) begin
                ent_d[i].a_rdy = 1'b1;
                ent_d[i].op.a  = cdb_data_i;
            end
            if (cdb_en_i && ent_q[i].valid && !ent_q[i].b_rdy && ent_q[i].b_id == cdb_rob_id_i) begin
                ent_d[i].b_rdy = 1'b1;
                ent_d[i].op.b  = cdb_data_i;
            end
        end
        if (do_issue) ent_d[sel_idx].valid = 1'b0;
        if (do_disp)  ent_d[free_idx] = new_e;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        alu_en_d = do_issue;
        iss_d    = iss_q;
        if (do_issue) iss_d = ent_q[sel_idx].op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss_q    <= '0;
            alu_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            iss_q    <= iss_d;
            alu_en_q <= alu_en_d;
        end
    end

    assign alu_en_o     = alu_en_q;
    assign alu_A_o      = iss_q.a;
    assign alu_B_o      = iss_q.b;
    assign alu_Imm_o    = iss_q.imm;
    assign alu_OP_o     = iss_q.op;
    assign alu_Funct7_o = iss_q.funct7;
    assign alu_Funct3_o = iss_q.funct3;
    assign alu_pc_o     = iss_q.pc;
    assign alu_ROB_id_o = iss_q.rob_id;
endmodule
